// File: rtl/decode_pkg.sv
// Shared decode definitions: opcode/funct constants, ALU and FPU op codes,
// the decoded control struct and the combinational decoder.
// Optional feature macro: FPU_DECODE_EN (COP1 single-precision arithmetic).
package decode_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_COP1  = 6'h11;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_SLT   = 6'h2A;

  localparam logic [4:0] FMT_S    = 5'h10;

  // Zero is reserved for "no operation" so a decoded op is never all-zero.
  localparam logic [2:0] ALU_NOP  = 3'd0;
  localparam logic [2:0] ALU_ADD  = 3'd1;
  localparam logic [2:0] ALU_SUB  = 3'd2;
  localparam logic [2:0] ALU_XOR  = 3'd3;
  localparam logic [2:0] ALU_SLT  = 3'd4;

  localparam logic [2:0] FPU_NOP  = 3'd0;
  localparam logic [2:0] FPU_ADD  = 3'd1;
  localparam logic [2:0] FPU_SUB  = 3'd2;
  localparam logic [2:0] FPU_MUL  = 3'd3;
  localparam logic [2:0] FPU_DIV  = 3'd4;

  typedef struct packed {
    logic       regWrite;
    logic       muxA_en;
    logic       dm_we;
    logic       muxWD3_en;
    logic       fpu_en;
    logic       illegal;
    logic [1:0] muxB_en;
    logic [1:0] regWriteAddSelect;
    logic [1:0] muxPC;
    logic [2:0] ALUop;
    logic [2:0] fpu_op;
  } dec_ctrl_t;

  // Anything not recognised leaves every field 0 except illegal.
  function automatic dec_ctrl_t decode_instr(input logic [31:0] instr, input logic zero);
    dec_ctrl_t  d;
    logic [5:0] op;
    logic [5:0] fn;
    d  = '0;
    op = instr[31:26];
    fn = instr[5:0];
    case (op)
      OP_RTYPE: begin
        case (fn)
          FN_ADD, FN_SUB, FN_SLT: begin
            d.regWrite          = 1'b1;
            d.muxB_en           = 2'd1;
            d.muxWD3_en         = 1'b1;
            d.regWriteAddSelect = 2'd2;
            d.ALUop = (fn == FN_ADD) ? ALU_ADD : (fn == FN_SUB) ? ALU_SUB : ALU_SLT;
          end
          FN_JR:   d.muxPC = 2'd2;
          default: d.illegal = 1'b1;
        endcase
      end
      OP_LW:   begin d.regWrite = 1'b1; d.ALUop = ALU_ADD; end
      OP_SW:   begin d.dm_we = 1'b1; d.ALUop = ALU_ADD; end
      OP_ADDI: begin d.regWrite = 1'b1; d.muxWD3_en = 1'b1; d.ALUop = ALU_ADD; end
      OP_XORI: begin d.regWrite = 1'b1; d.muxWD3_en = 1'b1; d.ALUop = ALU_XOR; end
      OP_J:    d.muxPC = 2'd1;
      OP_JAL: begin
        d.regWrite          = 1'b1;
        d.muxA_en           = 1'b1;
        d.muxB_en           = 2'd2;
        d.muxWD3_en         = 1'b1;
        d.regWriteAddSelect = 2'd1;
        d.muxPC             = 2'd1;
        d.ALUop             = ALU_ADD;
      end
      OP_BEQ, OP_BNE: begin
        d.muxB_en = 2'd1;
        d.ALUop   = ALU_SUB;
        // Branch resolved here from the zero flag sampled with the instruction.
        d.muxPC   = ((op == OP_BEQ) == zero) ? 2'd3 : 2'd0;
      end
`ifdef FPU_DECODE_EN
      OP_COP1: begin
        if (instr[25:21] == FMT_S && fn[5:2] == 4'd0) begin
          d.fpu_en   = 1'b1;
          d.regWrite = 1'b1;
          d.fpu_op   = {1'b0, fn[1:0]} + 3'd1;
        end else begin
          d.illegal = 1'b1;
        end
      end
`endif
      default: d.illegal = 1'b1;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/decode_fifo.sv
// Circular buffer of decoded entries; flush/reset empty it at the next edge
// and take priority over push and pop.
module decode_fifo
  import decode_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic             do_push, do_pop;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem_q[rd_ptr_q];

  // Pointer/count update; power-of-two depth lets pointers wrap naturally.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  // Storage write; a flushed push is dropped.
  always_comb begin
    mem_d = mem_q;
    if (do_push && !flush) mem_d[wr_ptr_q] = wdata;
  end

  // Control state register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload storage needs no reset: reads are masked while empty.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/decode_stage.sv
// Decode stage: decodes at enqueue, buffers decoded entries, presents the
// head to execute with a valid/ready handshake and an FPU interlock.
// Optional feature macro: FPU_DECODE_EN (without it, COP1 decodes illegal and
// fpu_en is never set, so fpu_busy has no effect).
module decode_stage
  import decode_pkg::*;
#(
  parameter int FIFO_DEPTH = 2,
  parameter int PC_W       = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [PC_W-1:0] in_pc,
  input  logic            in_zero,
  input  logic            flush,
  input  logic            fpu_busy,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            out_regWrite,
  output logic            out_muxA_en,
  output logic            out_dm_we,
  output logic            out_muxWD3_en,
  output logic            out_fpu_en,
  output logic            out_illegal,
  output logic [1:0]      out_muxB_en,
  output logic [1:0]      out_regWriteAddSelect,
  output logic [1:0]      out_muxPC,
  output logic [2:0]      out_ALUop,
  output logic [2:0]      out_fpu_op,
  output logic [31:0]     out_instr,
  output logic [PC_W-1:0] out_pc
);

  localparam int ENTRY_W = $bits(dec_ctrl_t) + 32 + PC_W;

  logic [ENTRY_W-1:0] wdata, rdata;
  logic               full, empty, push, pop, head_vld, stall;
  dec_ctrl_t          head, shown;
  logic [31:0]        head_instr;
  logic [PC_W-1:0]    head_pc;

  assign wdata = {decode_instr(in_instr, in_zero), in_instr, in_pc};
  assign {head, head_instr, head_pc} = rdata;

  assign in_ready  = !reset && !full;
  assign push      = in_valid && in_ready;
  assign head_vld  = !reset && !empty;
  // head.fpu_en can only be set when the FPU decoder is built in.
  assign stall     = head.fpu_en && fpu_busy;
  assign out_valid = head_vld && !stall;
  assign pop       = out_valid && out_ready;

  decode_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(ENTRY_W)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .push  (push),
    .pop   (pop),
    .wdata (wdata),
    .rdata (rdata),
    .full  (full),
    .empty (empty)
  );

  // Present the head entry, forced to zero while the buffer is empty.
  always_comb begin
    shown     = '0;
    out_instr = '0;
    out_pc    = '0;
    if (head_vld) begin
      shown     = head;
      out_instr = head_instr;
      out_pc    = head_pc;
    end
  end

  assign out_regWrite          = shown.regWrite;
  assign out_muxA_en           = shown.muxA_en;
  assign out_dm_we             = shown.dm_we;
  assign out_muxWD3_en         = shown.muxWD3_en;
  assign out_fpu_en            = shown.fpu_en;
  assign out_illegal           = shown.illegal;
  assign out_muxB_en           = shown.muxB_en;
  assign out_regWriteAddSelect = shown.regWriteAddSelect;
  assign out_muxPC             = shown.muxPC;
  assign out_ALUop             = shown.ALUop;
  assign out_fpu_op            = shown.fpu_op;

endmodule

// File: tb/tb_decode_stage.sv
// Directed self-checking bench for decode_stage (FIFO_DEPTH=2, PC_W=32).
module tb_decode_stage;
  import decode_pkg::*;

  logic        clk, reset;
  logic        in_valid, in_ready, in_zero, flush, fpu_busy;
  logic [31:0] in_instr, in_pc;
  logic        out_valid, out_ready;
  logic        out_regWrite, out_muxA_en, out_dm_we, out_muxWD3_en, out_fpu_en, out_illegal;
  logic [1:0]  out_muxB_en, out_regWriteAddSelect, out_muxPC;
  logic [2:0]  out_ALUop, out_fpu_op;
  logic [31:0] out_instr, out_pc;

  int n_tests = 0;
  int n_fail  = 0;

  decode_stage #(.FIFO_DEPTH(2), .PC_W(32)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .in_zero(in_zero), .flush(flush), .fpu_busy(fpu_busy),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_regWrite(out_regWrite), .out_muxA_en(out_muxA_en), .out_dm_we(out_dm_we),
    .out_muxWD3_en(out_muxWD3_en), .out_fpu_en(out_fpu_en), .out_illegal(out_illegal),
    .out_muxB_en(out_muxB_en), .out_regWriteAddSelect(out_regWriteAddSelect),
    .out_muxPC(out_muxPC), .out_ALUop(out_ALUop), .out_fpu_op(out_fpu_op),
    .out_instr(out_instr), .out_pc(out_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [13:0] pk(input logic rw, ma, dwe, wd3, ill,
                                     input logic [1:0] mb, rwas, mpc, input logic [2:0] alu);
    return {rw, ma, dwe, wd3, ill, mb, rwas, mpc, alu};
  endfunction

  function automatic logic [13:0] act_fields();
    return pk(out_regWrite, out_muxA_en, out_dm_we, out_muxWD3_en, out_illegal,
              out_muxB_en, out_regWriteAddSelect, out_muxPC, out_ALUop);
  endfunction

  task automatic push_one(input logic [31:0] ins, input logic [31:0] pc, input logic z);
    in_valid = 1'b1; in_instr = ins; in_pc = pc; in_zero = z;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic pop_one();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  // Push into an empty buffer, check the decoded head one cycle later, drain.
  task automatic dec_check(input string tag, input logic [31:0] ins, input logic z,
                           input logic [13:0] exp);
    push_one(ins, 32'h400, z);
    chk({tag, "_valid"}, 64'(out_valid), 64'd1);
    chk({tag, "_fields"}, 64'(act_fields()), 64'(exp));
    chk({tag, "_fpu"}, 64'({out_fpu_en, out_fpu_op}), 64'd0);
    pop_one();
    chk({tag, "_drained"}, 64'(out_valid), 64'd0);
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_instr = '0; in_pc = '0; in_zero = 1'b0;
    flush = 1'b0; fpu_busy = 1'b0; out_ready = 1'b0;

    // Reset state
    tick(); tick();
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_fields", 64'({act_fields(), out_instr, out_pc}), 64'd0);
    reset = 1'b0;
    #1;
    chk("post_rst_in_ready", 64'(in_ready), 64'd1);

    // ADD into empty buffer: valid after exactly one edge
    push_one(32'h00221820, 32'h100, 1'b0);
    chk("add_valid", 64'(out_valid), 64'd1);
    chk("add_fields", 64'(act_fields()), 64'(pk(1, 0, 0, 1, 0, 2'd1, 2'd2, 2'd0, ALU_ADD)));
    chk("add_instr", 64'(out_instr), 64'h00221820);
    chk("add_pc", 64'(out_pc), 64'h100);
    pop_one();
    chk("add_pop_empty", 64'(out_valid), 64'd0);
    chk("empty_zero", 64'({act_fields(), out_instr, out_pc}), 64'd0);

    // Decode table
    dec_check("sub",   32'h00221822, 1'b0, pk(1, 0, 0, 1, 0, 2'd1, 2'd2, 2'd0, ALU_SUB));
    dec_check("slt",   32'h0022182A, 1'b0, pk(1, 0, 0, 1, 0, 2'd1, 2'd2, 2'd0, ALU_SLT));
    dec_check("jr",    32'h03E00008, 1'b0, pk(0, 0, 0, 0, 0, 2'd0, 2'd0, 2'd2, ALU_NOP));
    dec_check("lw",    32'h8D280004, 1'b0, pk(1, 0, 0, 0, 0, 2'd0, 2'd0, 2'd0, ALU_ADD));
    dec_check("sw",    32'hAD280004, 1'b0, pk(0, 0, 1, 0, 0, 2'd0, 2'd0, 2'd0, ALU_ADD));
    dec_check("addi",  32'h20420005, 1'b0, pk(1, 0, 0, 1, 0, 2'd0, 2'd0, 2'd0, ALU_ADD));
    dec_check("xori",  32'h38420005, 1'b0, pk(1, 0, 0, 1, 0, 2'd0, 2'd0, 2'd0, ALU_XOR));
    dec_check("j",     32'h08000010, 1'b0, pk(0, 0, 0, 0, 0, 2'd0, 2'd0, 2'd1, ALU_NOP));
    dec_check("jal",   32'h0C000010, 1'b0, pk(1, 1, 0, 1, 0, 2'd2, 2'd1, 2'd1, ALU_ADD));
    dec_check("beq_t", 32'h10220003, 1'b1, pk(0, 0, 0, 0, 0, 2'd1, 2'd0, 2'd3, ALU_SUB));
    dec_check("beq_n", 32'h10220003, 1'b0, pk(0, 0, 0, 0, 0, 2'd1, 2'd0, 2'd0, ALU_SUB));
    dec_check("bne_t", 32'h14220003, 1'b0, pk(0, 0, 0, 0, 0, 2'd1, 2'd0, 2'd3, ALU_SUB));
    dec_check("bne_n", 32'h14220003, 1'b1, pk(0, 0, 0, 0, 0, 2'd1, 2'd0, 2'd0, ALU_SUB));
    dec_check("ill3f", 32'hFC000000, 1'b0, pk(0, 0, 0, 0, 1, 2'd0, 2'd0, 2'd0, ALU_NOP));
    dec_check("ill_fn",32'h00221821, 1'b0, pk(0, 0, 0, 0, 1, 2'd0, 2'd0, 2'd0, ALU_NOP));

    // Backpressure: fill, stall, pop then accept the third
    push_one(32'h8D280004, 32'h200, 1'b0);
    push_one(32'h8D280004, 32'h204, 1'b0);
    chk("full_in_ready", 64'(in_ready), 64'd0);
    chk("full_head_pc", 64'(out_pc), 64'h200);
    in_valid = 1'b1; in_instr = 32'h8D280004; in_pc = 32'h208;
    tick();
    chk("stall_in_ready", 64'(in_ready), 64'd0);
    chk("stall_head", 64'({out_valid, out_pc, act_fields()}),
        64'({1'b1, 32'h200, pk(1, 0, 0, 0, 0, 2'd0, 2'd0, 2'd0, ALU_ADD)}));
    out_ready = 1'b1;
    tick();   // full: only the pop happens
    out_ready = 1'b0;
    chk("pop_full_in_ready", 64'(in_ready), 64'd1);
    chk("pop_full_head", 64'(out_pc), 64'h204);
    tick();   // third entry accepted now
    in_valid = 1'b0;
    chk("third_in_ready", 64'(in_ready), 64'd0);
    chk("third_head", 64'(out_pc), 64'h204);
    pop_one();
    chk("after_pop_head", 64'(out_pc), 64'h208);
    // Simultaneous push and pop keeps count at 1
    in_valid = 1'b1; in_pc = 32'h20C; out_ready = 1'b1;
    tick();
    in_valid = 1'b0; out_ready = 1'b0;
    chk("pushpop_in_ready", 64'(in_ready), 64'd1);
    chk("pushpop_head", 64'({out_valid, out_pc}), 64'({1'b1, 32'h20C}));
    pop_one();
    chk("pushpop_drained", 64'(out_valid), 64'd0);

    // FPU interlock
    fpu_busy = 1'b1;
    push_one(32'h46020800, 32'h300, 1'b0);
`ifdef FPU_DECODE_EN
    chk("fpu_busy_valid", 64'(out_valid), 64'd0);
    out_ready = 1'b1;
    tick();
    chk("fpu_busy_hold", 64'(out_valid), 64'd0);
    out_ready = 1'b0;
    fpu_busy = 1'b0;
    #1;
    chk("fpu_free_valid", 64'(out_valid), 64'd1);
    chk("fpu_fields", 64'({out_fpu_en, out_fpu_op, out_regWrite, out_illegal}),
        64'({1'b1, FPU_ADD, 1'b1, 1'b0}));
`else
    chk("cop1_valid", 64'(out_valid), 64'd1);
    chk("cop1_illegal", 64'({out_illegal, out_fpu_en, out_fpu_op, out_regWrite}),
        64'({1'b1, 1'b0, 3'd0, 1'b0}));
    fpu_busy = 1'b0;
`endif
    pop_one();
    chk("fpu_drained", 64'(out_valid), 64'd0);

    // Flush with two entries and a concurrent push
    push_one(32'h00221820, 32'h500, 1'b0);
    push_one(32'h8D280004, 32'h504, 1'b0);
    chk("pre_flush_full", 64'(in_ready), 64'd0);
    flush = 1'b1; in_valid = 1'b1; in_instr = 32'hAD280004; in_pc = 32'h508;
    out_ready = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    chk("flush_valid", 64'(out_valid), 64'd0);
    chk("flush_in_ready", 64'(in_ready), 64'd1);
    push_one(32'h20420005, 32'h600, 1'b0);
    chk("post_flush_head", 64'({out_valid, out_pc}), 64'({1'b1, 32'h600}));
    pop_one();
    chk("post_flush_count0", 64'(out_valid), 64'd0);

    // Reset mid-operation discards contents
    push_one(32'h00221820, 32'h700, 1'b0);
    push_one(32'h00221820, 32'h704, 1'b0);
    reset = 1'b1; out_ready = 1'b1;
    tick();
    chk("midrst_in_ready", 64'(in_ready), 64'd0);
    chk("midrst_valid", 64'(out_valid), 64'd0);
    reset = 1'b0; out_ready = 1'b0;
    #1;
    chk("midrst_after", 64'({in_ready, out_valid, out_pc}), 64'({1'b1, 1'b0, 32'h0}));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
